// File: rtl/ace_snap_rle_loader_if.sv
// rtl/ace_snap_rle_loader_if.sv - data_io byte stream in, ace loader write port out
interface ace_snap_rle_loader_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [15:0] loader_addr;
  logic [7:0]  loader_data;
  logic        loader_wr;
  logic        loader_en;
  logic        loader_reset;
  logic        done;
  logic        error;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_dout,
    input  ioctl_wait, loader_addr, loader_data, loader_wr, loader_en,
           loader_reset, done, error
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_dout,
    output ioctl_wait, loader_addr, loader_data, loader_wr, loader_en,
           loader_reset, done, error
  );
endinterface

// File: rtl/ace_snap_rle_loader.sv
// rtl/ace_snap_rle_loader.sv - Jupiter Ace RLE snapshot decoder feeding the ace RAM loader port
module ace_snap_rle_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h2000,
  parameter logic [15:0] MAX_ADDR  = 16'h7FFF,
  parameter logic [7:0]  ESC_BYTE  = 8'hED
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  ace_snap_rle_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LIT, ESC, CNT, RUN, END} state_t;

  state_t      state, state_nx;
  logic [15:0] addr;
  logic [7:0]  cnt, val, data_q;
  logic        emit_q, dl_q, done_q, error_q;
  logic        dl_rise, dl_fall, byte_in, over_max;
  logic        emit, err_set;
  logic [7:0]  emit_byte;

  assign dl_rise  = bus.ioctl_download & ~dl_q;
  assign dl_fall  = ~bus.ioctl_download & dl_q;
  assign byte_in  = bus.ioctl_wr & bus.ioctl_download;
  assign over_max = addr > MAX_ADDR;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (dl_rise) begin
      state_nx = LIT;
    end else begin
      case (state)
        IDLE: state_nx = IDLE;
        LIT: begin
          if (dl_fall) state_nx = IDLE;
          else if (byte_in && bus.ioctl_dout == ESC_BYTE) state_nx = ESC;
        end
        ESC: begin
          if (dl_fall) state_nx = IDLE;
          else if (byte_in) state_nx = (bus.ioctl_dout == 8'h00) ? END : CNT;
        end
        CNT: begin
          if (dl_fall) state_nx = IDLE;
          else if (byte_in) state_nx = RUN;
        end
        // a dropped download lets the run drain before going idle
        RUN: if (cnt <= 8'd1) state_nx = bus.ioctl_download ? LIT : IDLE;
        END: if (dl_fall) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    emit      = 1'b0;
    emit_byte = bus.ioctl_dout;
    err_set   = emit_q & over_max;
    if (!dl_rise) begin
      case (state)
        LIT: emit = byte_in && (bus.ioctl_dout != ESC_BYTE);
        ESC: err_set = err_set | dl_fall;
        CNT: begin
          emit    = byte_in;
          err_set = err_set | dl_fall;
        end
        RUN: begin
          emit      = cnt > 8'd1;
          emit_byte = val;
          err_set   = err_set | byte_in;
        end
        default: emit = 1'b0;
      endcase
    end
  end

  // cnt counts run writes still owed, including the one on the bus this cycle
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      addr    <= BASE_ADDR;
      cnt     <= 8'd0;
      val     <= 8'd0;
      data_q  <= 8'd0;
      emit_q  <= 1'b0;
      dl_q    <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      dl_q <= bus.ioctl_download;
      if (dl_rise) begin
        addr    <= BASE_ADDR;
        cnt     <= 8'd0;
        emit_q  <= 1'b0;
        done_q  <= 1'b0;
        error_q <= 1'b0;
      end else begin
        emit_q <= emit;
        if (emit) data_q <= emit_byte;
        if (emit_q && addr != 16'hFFFF) addr <= addr + 16'd1;
        if (err_set) error_q <= 1'b1;
        if (state == ESC && byte_in) begin
          if (bus.ioctl_dout == 8'h00) done_q <= 1'b1;
          else                         cnt    <= bus.ioctl_dout;
        end
        if (state == CNT && byte_in) val <= bus.ioctl_dout;
        if (state == RUN && cnt > 8'd1) cnt <= cnt - 8'd1;
      end
    end
  end

  assign bus.ioctl_wait   = (state == RUN);
  assign bus.loader_addr  = addr;
  assign bus.loader_data  = data_q;
  assign bus.loader_wr    = emit_q & ~over_max;
  assign bus.loader_en    = bus.ioctl_download | (state == RUN);
  assign bus.loader_reset = bus.loader_en;
  assign bus.done         = done_q;
  assign bus.error        = error_q;
endmodule
